// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
`timescale 1ns/1ps
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    localparam int GRANT_TIMEOUT_DEF = 16;
    localparam int XFER_TIMEOUT_DEF  = 1024;
    localparam int MAX_MASTERS       = 8;

    // Returns {found, index} of the first set request at or above ptr, wrapping at n.
    function automatic logic [3:0] next_requester(input logic [7:0] req,
                                                  input logic [2:0] ptr,
                                                  input int         n);
        logic [3:0] res;
        logic [3:0] cand;
        res = 4'd0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            cand = {1'b0, ptr} + 4'(i);
            if (cand >= 4'(n)) cand = cand - 4'(n);
            if (i < n && !res[3] && req[cand[2:0]]) res = {1'b1, cand[2:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_rr_pick.sv
// Combinational rotating-base priority selector: first request at or above ptr_i wins.
`timescale 1ns/1ps
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    input  logic [2:0]   ptr_i,
    output logic [N-1:0] onehot_o,
    output logic [2:0]   idx_o,
    output logic         valid_o
);

    logic [7:0] req_ext;
    logic [3:0] pick;

    always_comb begin
        req_ext = 8'(req_i);
        pick    = next_requester(req_ext, ptr_i, N);
        valid_o = pick[3];
        idx_o   = pick[2:0];
        for (int i = 0; i < N; i++) begin
            onehot_o[i] = pick[3] && (pick[2:0] == 3'(i));
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with grant and transfer watchdogs.
// Optional: BUS_ARB_FIXED_PRIO0_EN gives master 0 absolute priority over the round-robin group.
`timescale 1ns/1ps
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS   = 4,
    parameter int GRANT_TIMEOUT = GRANT_TIMEOUT_DEF,
    parameter int XFER_TIMEOUT  = XFER_TIMEOUT_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] bus_request,
    input  logic                   begin_transaction,
    input  logic                   end_transaction,
    output logic [NUM_MASTERS-1:0] bus_aquire,
    output logic                   bus_error,
    output logic                   bus_busy,
    output logic [2:0]             grant_id,
    output arb_state_e             state_o
);

    localparam int GT_W = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
    localparam int XT_W = (XFER_TIMEOUT > 1) ? $clog2(XFER_TIMEOUT) : 1;
    localparam logic [GT_W-1:0] GT_LAST = GT_W'(GRANT_TIMEOUT - 1);
    localparam logic [XT_W-1:0] XT_LAST = XT_W'(XFER_TIMEOUT - 1);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] aquire_q, aquire_d;
    logic                   error_q, error_d;
    logic [2:0]             gid_q, gid_d;
    logic [2:0]             ptr_q, ptr_d;
    logic [GT_W-1:0]        gtmr_q, gtmr_d;
    logic [XT_W-1:0]        xtmr_q, xtmr_d;

    logic [NUM_MASTERS-1:0] pick_req, pick_onehot, sel_onehot;
    logic [2:0]             pick_idx, sel_idx, ptr_next;
    logic                   pick_valid, sel_valid, accept_moves_ptr, req_held;

    rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req_i    (pick_req),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

`ifdef BUS_ARB_FIXED_PRIO0_EN
    // Master 0 sits outside the rotation; others rotate among themselves.
    always_comb begin
        pick_req    = bus_request;
        pick_req[0] = 1'b0;
    end
    assign sel_valid        = bus_request[0] | pick_valid;
    assign sel_idx          = bus_request[0] ? 3'd0 : pick_idx;
    assign sel_onehot       = bus_request[0] ? NUM_MASTERS'(1) : pick_onehot;
    assign accept_moves_ptr = (gid_q != 3'd0);
`else
    assign pick_req         = bus_request;
    assign sel_valid        = pick_valid;
    assign sel_idx          = pick_idx;
    assign sel_onehot       = pick_onehot;
    assign accept_moves_ptr = 1'b1;
`endif

    assign req_held = |(bus_request & aquire_q);
    assign ptr_next = (gid_q == 3'(NUM_MASTERS - 1)) ? 3'd0 : gid_q + 3'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            aquire_q <= '0;
            error_q  <= 1'b0;
            gid_q    <= 3'd0;
            ptr_q    <= 3'd0;
            gtmr_q   <= '0;
            xtmr_q   <= '0;
        end else begin
            state_q  <= state_d;
            aquire_q <= aquire_d;
            error_q  <= error_d;
            gid_q    <= gid_d;
            ptr_q    <= ptr_d;
            gtmr_q   <= gtmr_d;
            xtmr_q   <= xtmr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        aquire_d = aquire_q;
        error_d  = 1'b0;
        gid_d    = gid_q;
        ptr_d    = ptr_q;
        gtmr_d   = gtmr_q;
        xtmr_d   = xtmr_q;
        unique case (state_q)
            IDLE: begin
                aquire_d = '0;
                if (sel_valid) begin
                    state_d  = GRANT;
                    aquire_d = sel_onehot;
                    gid_d    = sel_idx;
                    gtmr_d   = '0;
                end
            end
            GRANT: begin
                // Begin takes precedence; a same-cycle end makes it a single-beat transfer.
                if (begin_transaction) begin
                    if (accept_moves_ptr) ptr_d = ptr_next;
                    xtmr_d = '0;
                    if (end_transaction) begin
                        state_d  = RELEASE;
                        aquire_d = '0;
                    end else begin
                        state_d = XFER;
                    end
                end else if (!req_held) begin
                    state_d  = RELEASE;
                    aquire_d = '0;
                end else if (gtmr_q == GT_LAST) begin
                    error_d  = 1'b1;
                    state_d  = RELEASE;
                    aquire_d = '0;
                end else if (gtmr_q != '1) begin
                    gtmr_d = gtmr_q + 1'b1;
                end
            end
            XFER: begin
                if (end_transaction) begin
                    state_d  = RELEASE;
                    aquire_d = '0;
                end else if (xtmr_q == XT_LAST) begin
                    error_d  = 1'b1;
                    state_d  = RELEASE;
                    aquire_d = '0;
                end else if (xtmr_q != '1) begin
                    xtmr_d = xtmr_q + 1'b1;
                end
            end
            RELEASE: begin
                aquire_d = '0;
                state_d  = IDLE;
            end
            default: begin
                aquire_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    assign bus_aquire = aquire_q;
    assign bus_error  = error_q;
    assign bus_busy   = (state_q != IDLE);
    assign grant_id   = gid_q;
    assign state_o    = state_q;

    a_grant_onehot0: assert property (@(posedge clock) disable iff (reset) $onehot0(aquire_q));

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: vector table, grant scoreboard and timeout sequences.
`timescale 1ns/1ps
module tb_bus_arbiter_rr;
  import bus_arb_pkg::*;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] bus_request = '0;
  logic         begin_transaction = 1'b0;
  logic         end_transaction = 1'b0;
  logic [N-1:0] bus_aquire;
  logic         bus_error;
  logic         bus_busy;
  logic [2:0]   grant_id;
  arb_state_e   state_o;

  int n_checks = 0;
  int n_err    = 0;

  logic [2:0]   exp_q[$];
  logic [N-1:0] prev_aq = '0;

  typedef struct {
    logic [N-1:0] req;
    logic [2:0]   exp_id;
  } vec_t;
  vec_t vecs[8];

  bus_arbiter_rr #(.NUM_MASTERS(N)) dut (
    .clock             (clock),
    .reset             (reset),
    .bus_request       (bus_request),
    .begin_transaction (begin_transaction),
    .end_transaction   (end_transaction),
    .bus_aquire        (bus_aquire),
    .bus_error         (bus_error),
    .bus_busy          (bus_busy),
    .grant_id          (grant_id),
    .state_o           (state_o)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_request = '0;
    begin_transaction = 1'b0;
    end_transaction = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic wait_grant(output int waited);
    waited = 0;
    while (bus_aquire == '0 && waited < 20) begin
      tick();
      waited++;
    end
    check("grant_seen", 32'(bus_aquire != '0), 1);
  endtask

  // scoreboard: every new grant is matched against the oldest prediction
  always @(negedge clock) begin
    logic [2:0]   e;
    logic [N-1:0] oh;
    if (bus_aquire != '0 && prev_aq == '0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_grant: got id %0d expected no grant", grant_id);
      end else begin
        e  = exp_q.pop_front();
        oh = '0;
        oh[e[1:0]] = 1'b1;
        check("sb_grant_id", 32'(grant_id), 32'(e));
        check("sb_grant_onehot", 32'(bus_aquire), 32'(oh));
      end
    end
    prev_aq = bus_aquire;
  end

  initial begin
    int w;
    int cnt;

`ifdef BUS_ARB_FIXED_PRIO0_EN
    vecs[0] = '{4'b0100, 3'd2}; vecs[1] = '{4'b0011, 3'd0};
    vecs[2] = '{4'b1010, 3'd3}; vecs[3] = '{4'b1001, 3'd0};
    vecs[4] = '{4'b0110, 3'd1}; vecs[5] = '{4'b0001, 3'd0};
    vecs[6] = '{4'b1100, 3'd2}; vecs[7] = '{4'b1000, 3'd3};
`else
    vecs[0] = '{4'b0100, 3'd2}; vecs[1] = '{4'b0011, 3'd0};
    vecs[2] = '{4'b1010, 3'd1}; vecs[3] = '{4'b1001, 3'd3};
    vecs[4] = '{4'b0110, 3'd1}; vecs[5] = '{4'b0001, 3'd0};
    vecs[6] = '{4'b1100, 3'd2}; vecs[7] = '{4'b1000, 3'd3};
`endif

    // reset state
    do_reset();
    check("rst_aquire", 32'(bus_aquire), 0);
    check("rst_error", 32'(bus_error), 0);
    check("rst_busy", 32'(bus_busy), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_state", 32'(state_o), 32'(IDLE));

    // single request, begin, end 8 cycles later
    exp_q.push_back(3'd2);
    bus_request = 4'b0100;
    wait_grant(w);
    check("t1_latency", 32'(w), 1);
    check("t1_aquire", 32'(bus_aquire), 32'(4'b0100));
    check("t1_busy", 32'(bus_busy), 1);
    begin_transaction = 1'b1;
    tick();
    begin_transaction = 1'b0;
    bus_request = '0;
    check("t1_xfer", 32'(state_o), 32'(XFER));
    repeat (7) tick();
    end_transaction = 1'b1;
    tick();
    end_transaction = 1'b0;
    check("t1_drop", 32'(bus_aquire), 0);
    check("t1_busy_release", 32'(bus_busy), 1);
    tick();
    check("t1_busy_idle", 32'(bus_busy), 0);

    // vector table: pointer carries across entries
    do_reset();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(vecs[i].exp_id);
      bus_request = vecs[i].req;
      wait_grant(w);
      check($sformatf("vec%0d_latency", i), 32'(w), 1);
      begin_transaction = 1'b1;
      bus_request = '0;
      tick();
      begin_transaction = 1'b0;
      repeat (2) tick();
      end_transaction = 1'b1;
      tick();
      end_transaction = 1'b0;
      tick();
      check($sformatf("vec%0d_idle", i), 32'(bus_busy), 0);
    end

    // all requesting: rotation with release/idle gap
    do_reset();
    for (int i = 0; i < 5; i++) begin
`ifdef BUS_ARB_FIXED_PRIO0_EN
      exp_q.push_back(3'd0);
`else
      exp_q.push_back(3'(i % N));
`endif
    end
    bus_request = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(w);
      check($sformatf("t2_gap%0d", i), 32'(w), (i == 0) ? 1 : 2);
      begin_transaction = 1'b1;
      tick();
      begin_transaction = 1'b0;
      repeat (2) tick();
      end_transaction = 1'b1;
      tick();
      end_transaction = 1'b0;
      check($sformatf("t2_release%0d", i), 32'(state_o), 32'(RELEASE));
      if (i == 4) bus_request = '0;
    end
    repeat (2) tick();
    check("t2_idle", 32'(bus_busy), 0);

    // grant timeout keeps the pointer
    do_reset();
    exp_q.push_back(3'd0);
    bus_request = 4'b0001;
    wait_grant(w);
    begin_transaction = 1'b1;
    bus_request = '0;
    tick();
    begin_transaction = 1'b0;
    end_transaction = 1'b1;
    tick();
    end_transaction = 1'b0;
    tick();
    exp_q.push_back(3'd1);
    bus_request = 4'b1010;
    wait_grant(w);
    cnt = 0;
    while (!bus_error && cnt < 40) begin
      tick();
      cnt++;
    end
    check("t3_timeout_cycles", 32'(cnt), 16);
    check("t3_grant_dropped", 32'(bus_aquire), 0);
    check("t3_release", 32'(state_o), 32'(RELEASE));
    exp_q.push_back(3'd1);
    tick();
    check("t3_err_pulse_width", 32'(bus_error), 0);
    wait_grant(w);
    check("t3_regrant_latency", 32'(w), 1);
    // single-beat transfer: begin and end together
    begin_transaction = 1'b1;
    end_transaction = 1'b1;
    bus_request = '0;
    tick();
    begin_transaction = 1'b0;
    end_transaction = 1'b0;
    check("t3_single_beat_release", 32'(state_o), 32'(RELEASE));
    check("t3_single_beat_err", 32'(bus_error), 0);
    tick();
    exp_q.push_back(3'd3);
    bus_request = 4'b1010;
    wait_grant(w);
    // withdrawn grant: no error, pointer unchanged
    bus_request = '0;
    tick();
    check("t3_withdraw_release", 32'(state_o), 32'(RELEASE));
    check("t3_withdraw_err", 32'(bus_error), 0);
    tick();
    exp_q.push_back(3'd2);
    bus_request = 4'b1110;
    wait_grant(w);
    bus_request = '0;
    repeat (2) tick();
    check("t3_idle", 32'(bus_busy), 0);

    // transfer timeout, then completion on the timeout cycle
    do_reset();
    exp_q.push_back(3'd0);
    bus_request = 4'b0001;
    wait_grant(w);
    begin_transaction = 1'b1;
    bus_request = '0;
    tick();
    begin_transaction = 1'b0;
    cnt = 0;
    while (!bus_error && cnt < 1100) begin
      tick();
      cnt++;
    end
    check("t4_xfer_timeout_cycles", 32'(cnt), 1024);
    check("t4_grant_dropped", 32'(bus_aquire), 0);
    tick();
    check("t4_err_pulse_width", 32'(bus_error), 0);
    tick();
    exp_q.push_back(3'd0);
    bus_request = 4'b0001;
    wait_grant(w);
    begin_transaction = 1'b1;
    bus_request = '0;
    tick();
    begin_transaction = 1'b0;
    repeat (1023) tick();
    end_transaction = 1'b1;
    tick();
    end_transaction = 1'b0;
    check("t4_end_wins_err", 32'(bus_error), 0);
    check("t4_end_wins_release", 32'(state_o), 32'(RELEASE));
    tick();

    // reset during transfer
    exp_q.push_back(3'd0);
    bus_request = 4'b0001;
    wait_grant(w);
    begin_transaction = 1'b1;
    bus_request = '0;
    tick();
    begin_transaction = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("t5_aquire", 32'(bus_aquire), 0);
    check("t5_error", 32'(bus_error), 0);
    check("t5_state", 32'(state_o), 32'(IDLE));
    check("t5_grant_id", 32'(grant_id), 0);
    reset = 1'b0;
    tick();

    // new requests arriving during a transfer
    do_reset();
    exp_q.push_back(3'd1);
    bus_request = 4'b1110;
    wait_grant(w);
    begin_transaction = 1'b1;
    tick();
    begin_transaction = 1'b0;
    bus_request = 4'b1111;
    bus_request = bus_request & ~bus_aquire;
`ifdef BUS_ARB_FIXED_PRIO0_EN
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd2);
`else
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd3);
`endif
    repeat (3) tick();
    end_transaction = 1'b1;
    tick();
    end_transaction = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_grant(w);
      check($sformatf("t6_gap%0d", i), 32'(w), 2);
      bus_request = bus_request & ~bus_aquire;
      if (i == 1) bus_request = '0;
      begin_transaction = 1'b1;
      tick();
      begin_transaction = 1'b0;
      tick();
      end_transaction = 1'b1;
      tick();
      end_transaction = 1'b0;
    end
    repeat (3) tick();
    check("t6_idle", 32'(bus_busy), 0);

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
